wsp_serial_capture: RTL and testbench

- Serial-in, parallel-out capture stage; the downstream consumer of the parallel-in/serial-out shifter.
- Assembles LSB-first serial bits into `size`-bit words and double-buffers each completed word into a holding register.
- Presents each word with a valid/ready handshake to the IEEE 1500 wrapper capture/compare logic.
- Flags overrun when a word completes while the previous one is still unconsumed.

---
 rtl/wsp_pkg.sv | 13 +
 rtl/wsp_serial_capture.sv | 117 +++++++++++
 tb/tb_wsp_serial_capture.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wsp_pkg.sv
// Shared constants for the wrapper serial path; the upstream shifter and the capture stage
// both take their word size from here.
package wsp_pkg;

   localparam int unsigned WSP_WORD_SIZE = 12;
   localparam int unsigned WSP_CNT_W     = 4;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_e;

endpackage

// File: rtl/wsp_serial_capture.sv
// Serial-in/parallel-out capture: assembles LSB-first bits into words and double-buffers
// each finished word into a valid/ready holding register with a sticky overrun flag.
module wsp_serial_capture
   import wsp_pkg::*;
#(
   parameter int unsigned size  = WSP_WORD_SIZE,
   parameter int unsigned CNT_W = WSP_CNT_W
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             serial_in,
   input  logic             shift_en,
   input  logic             sync,
   input  logic             data_ready,
   input  logic             ovr_clr,
   output logic [size:1]    data_out,
   output logic             data_valid,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_count,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(size - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic [size:1]    sh_q, sh_d;
   logic [size:1]    sh_shift, sh_sync;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [size:1]    data_q, data_d;
   logic             ovr_q, ovr_d;
   hold_e            hold_q, hold_d;
   logic             word_done;
   logic [size:1]    word;

   // Shifted and sync-restarted images of the shift register, written so size=1 stays legal.
   always_comb begin
      sh_shift       = sh_q >> 1;
      sh_shift[size] = serial_in;
      sh_sync        = '0;
      sh_sync[size]  = serial_in;
   end

   always_comb begin
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      word      = sh_shift;
      if (sync) begin
         if (shift_en) begin
            sh_d      = sh_sync;
            word      = sh_sync;
            word_done = (size == 1);
            cnt_d     = (size == 1) ? '0 : CntOne;
         end else begin
            sh_d  = '0;
            cnt_d = '0;
         end
      end else if (shift_en) begin
         sh_d      = sh_shift;
         word_done = (cnt_q == CntLast);
         cnt_d     = word_done ? '0 : cnt_q + CntOne;
      end
   end

   always_comb begin
      hold_d = hold_q;
      data_d = data_q;
      ovr_d  = ovr_q;
      if (ovr_clr) begin
         ovr_d = 1'b0;
      end
      unique case (hold_q)
         HOLD_EMPTY: begin
            if (word_done) begin
               data_d = word;
               hold_d = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            if (data_ready) begin
               if (word_done) begin
                  data_d = word;
               end else begin
                  hold_d = HOLD_EMPTY;
               end
            end else if (word_done) begin
               // Set beats a simultaneous ovr_clr.
               ovr_d = 1'b1;
            end
         end
         default: hold_d = HOLD_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         ovr_q  <= 1'b0;
         hold_q <= HOLD_EMPTY;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         ovr_q  <= ovr_d;
         hold_q <= hold_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = (hold_q == HOLD_FULL);
   assign overrun    = ovr_q;
   assign bit_count  = cnt_q;
   assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_wsp_serial_capture.sv
// Directed bench for wsp_serial_capture: hand-computed expectations for reset, capture,
// back-to-back, overrun, sync alignment and stall.
module tb_wsp_serial_capture;
   import wsp_pkg::*;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic        serial_in = 1'b0;
   logic        shift_en = 1'b0;
   logic        sync = 1'b0;
   logic        data_ready = 1'b0;
   logic        ovr_clr = 1'b0;
   logic [12:1] data_out;
   logic        data_valid;
   logic        overrun;
   logic [3:0]  bit_count;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wsp_serial_capture #(
      .size  (WSP_WORD_SIZE),
      .CNT_W (WSP_CNT_W)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .serial_in  (serial_in),
      .shift_en   (shift_en),
      .sync       (sync),
      .data_ready (data_ready),
      .ovr_clr    (ovr_clr),
      .data_out   (data_out),
      .data_valid (data_valid),
      .overrun    (overrun),
      .bit_count  (bit_count),
      .busy       (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shifts bits lo..hi of w, LSB first, one per edge.
   task automatic send_bits(input logic [11:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         serial_in = w[i];
         shift_en  = 1'b1;
         tick();
      end
      shift_en  = 1'b0;
      serial_in = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, ".data_out"}, 32'(data_out), 32'h0);
      check_val({tag, ".valid"}, 32'(data_valid), 32'h0);
      check_val({tag, ".overrun"}, 32'(overrun), 32'h0);
      check_val({tag, ".bit_count"}, 32'(bit_count), 32'h0);
      check_val({tag, ".busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check_idle("rst");
      clr = 1'b1;
      send_bits(12'hFFF, 0, 4);
      check_val("pre_rst.bit_count", 32'(bit_count), 32'd5);
      check_val("pre_rst.busy", 32'(busy), 32'h1);
      clr = 1'b0;
      tick();
      check_idle("mid_rst");
      clr = 1'b1;

      // Basic capture, also proves no remnant of the 5 discarded bits
      data_ready = 1'b1;
      send_bits(12'hA5C, 0, 10);
      check_val("basic.pre_valid", 32'(data_valid), 32'h0);
      check_val("basic.bit_count11", 32'(bit_count), 32'd11);
      send_bits(12'hA5C, 11, 11);
      check_val("basic.valid", 32'(data_valid), 32'h1);
      check_val("basic.data", 32'(data_out), 32'hA5C);
      check_val("basic.bit_count", 32'(bit_count), 32'h0);
      tick();
      check_val("basic.drop", 32'(data_valid), 32'h0);
      check_val("basic.stale", 32'(data_out), 32'hA5C);

      // Back-to-back
      send_bits(12'h123, 0, 11);
      check_val("b2b.data1", 32'(data_out), 32'h123);
      data_ready = 1'b0;
      send_bits(12'hFED, 0, 10);
      check_val("b2b.hold_valid", 32'(data_valid), 32'h1);
      check_val("b2b.hold_data", 32'(data_out), 32'h123);
      data_ready = 1'b1;
      send_bits(12'hFED, 11, 11);
      check_val("b2b.valid", 32'(data_valid), 32'h1);
      check_val("b2b.data2", 32'(data_out), 32'hFED);
      check_val("b2b.overrun", 32'(overrun), 32'h0);
      tick();
      check_val("b2b.drop", 32'(data_valid), 32'h0);

      // Overrun
      data_ready = 1'b0;
      send_bits(12'h0F0, 0, 11);
      check_val("ovr.data1", 32'(data_out), 32'h0F0);
      send_bits(12'h111, 0, 11);
      check_val("ovr.flag", 32'(overrun), 32'h1);
      check_val("ovr.data_kept", 32'(data_out), 32'h0F0);
      check_val("ovr.valid", 32'(data_valid), 32'h1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check_val("ovr.cleared", 32'(overrun), 32'h0);
      send_bits(12'h333, 0, 10);
      ovr_clr = 1'b1;
      send_bits(12'h333, 11, 11);
      ovr_clr = 1'b0;
      check_val("ovr.set_wins", 32'(overrun), 32'h1);
      check_val("ovr.data_kept2", 32'(data_out), 32'h0F0);
      ovr_clr    = 1'b1;
      data_ready = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check_val("ovr.final_clr", 32'(overrun), 32'h0);
      check_val("ovr.consumed", 32'(data_valid), 32'h0);

      // sync without shift discards the partial word
      send_bits(12'h007, 0, 2);
      check_val("sync0.pre", 32'(bit_count), 32'd3);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check_val("sync0.bit_count", 32'(bit_count), 32'h0);
      check_val("sync0.busy", 32'(busy), 32'h0);

      // sync with shift starts a new word on that bit
      send_bits(12'h055, 0, 6);
      sync      = 1'b1;
      shift_en  = 1'b1;
      serial_in = 1'b1;
      tick();
      sync     = 1'b0;
      shift_en = 1'b0;
      check_val("sync1.bit_count", 32'(bit_count), 32'd1);
      check_val("sync1.valid", 32'(data_valid), 32'h0);
      send_bits(12'h801, 1, 11);
      check_val("sync1.valid2", 32'(data_valid), 32'h1);
      check_val("sync1.data", 32'(data_out), 32'h801);
      tick();

      // Stall mid-word
      send_bits(12'h5A3, 0, 5);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("stall.bit_count", 32'(bit_count), 32'd6);
         check_val("stall.busy", 32'(busy), 32'h1);
      end
      check_val("stall.no_valid", 32'(data_valid), 32'h0);
      send_bits(12'h5A3, 6, 11);
      check_val("stall.valid", 32'(data_valid), 32'h1);
      check_val("stall.data", 32'(data_out), 32'h5A3);
      check_val("stall.overrun", 32'(overrun), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
